periph_dma: RTL and testbench
=============================

PERIPH_DMA -- requirements
Module: periph_dma

Interface
REQ-001 Parameter LEN_W, default 24, width of the word-count register and counter.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 reg_wr  in  1  CPU register write strobe, one cycle per write.
REQ-005 reg_addr  in  3  register select: 0 SRC, 1 DST, 2 LEN, 3 FILL, 4 CTRL, 5 STATUS.
REQ-006 reg_wdata  in  32  CPU write data.
REQ-007 reg_rdata  out  32  combinational read of the register selected by reg_addr; unused offsets return 0.
REQ-008 dma_rd  out  1  SDRAM read request, held until acked.
REQ-009 dma_wr  out  1  SDRAM write request, held until acked.
REQ-010 dma_addr  out  24  SDRAM word address.
REQ-011 dma_wdata  out  32  write data.
REQ-012 dma_wstrb  out  4  byte strobes, constant 4'b1111.
REQ-013 dma_active  out  1  high whenever the engine is not IDLE.
REQ-014 sdram_ack  in  1  one-cycle completion of the outstanding request; for reads, sdram_rdata is valid in the same cycle.
REQ-015 sdram_rdata  in  32  read data.
REQ-016 irq_done  out  1  one-cycle pulse on transfer completion or abort.

Function
REQ-017 Registers: SRC[23:0] and DST[23:0] are word addresses; LEN[LEN_W-1:0] is the word count; FILL is 32 bits. CTRL bit0 = start (self-clearing), bit1 = mode (0 copy, 1 fill), bit2 = abort (self-clearing).
REQ-018 STATUS SHALL read {busy in bit31, done in bit30, zero bits 29:24, remaining count in bits 23:0}. done is sticky and is cleared by the next start.
REQ-019 FSM states SHALL be IDLE, RD, WR.
REQ-020 Start in IDLE with LEN≠0 SHALL latch SRC, DST and LEN into working counters and go to WR in fill mode or RD in copy mode.
REQ-021 Start in IDLE with LEN=0 SHALL stay in IDLE, set done and pulse irq_done on the next cycle.
REQ-022 RD: dma_rd=1 and dma_addr=working src. On sdram_ack, capture sdram_rdata, increment src and go to WR.
REQ-023 WR: dma_wr=1 and dma_addr=working dst. dma_wdata SHALL be FILL in fill mode and the captured data in copy mode.
REQ-024 On sdram_ack in WR, increment dst and decrement remaining. If remaining was 1, go to IDLE, set done and pulse irq_done; otherwise go to RD (copy) or stay in WR (fill).
REQ-025 dma_rd and dma_wr SHALL never be high together, and SHALL both be low in IDLE.
REQ-026 Request outputs SHALL be registered; a new request SHALL be issued no earlier than the cycle after the ack of the previous one.
REQ-027 Addresses SHALL wrap modulo 2^24 (0xFFFFFF+1 = 0x000000).
REQ-028 Writes to SRC, DST, LEN, FILL and mode while busy SHALL be ignored; start while busy SHALL be ignored.
REQ-029 Abort while busy: the outstanding request SHALL be held until its ack. The engine SHALL then go to IDLE, pulse irq_done, leave done=0 and keep remaining readable.
REQ-030 Simultaneous abort and start writes SHALL resolve as abort; the start is discarded.
REQ-031 Programmed registers SHALL be unchanged by a transfer, so a re-start repeats the same job.

Reset
REQ-032 Asserting reset_n low SHALL force state IDLE, all registers, counters and captured data to 0, and all outputs low except dma_wstrb=4'b1111. It SHALL abandon any in-flight request; the arbiter is reset by the same reset_n.

Structure
REQ-033 Package pq_dma_pkg SHALL hold the register offsets, the CTRL and STATUS bit positions, and the state enum.
REQ-034 Single module with no sub-modules; the register file and FSM live in periph_dma.

Verification
REQ-035 Copy: SRC=0x000100, DST=0x000200, LEN=3, ack 2 cycles after each request. Expect 3 RD/WR pairs to 0x200..0x202 with data matching the reads, one irq_done, and STATUS=0x4000_0000.
REQ-036 Fill: FILL=0xDEADBEEF, DST=0x000010, LEN=4. Expect 4 consecutive writes of 0xDEADBEEF to 0x10..0x13 and no dma_rd.
REQ-037 Wrap: copy with SRC=0xFFFFFE, LEN=3. Expect read addresses 0xFFFFFE, 0xFFFFFF, 0x000000.
REQ-038 LEN=0 start: expect no requests, irq_done one cycle later, and done=1.
REQ-039 Abort in copy LEN=8 after 2 writes, with ack delayed 5 cycles: expect the request held until ack, then IDLE, irq_done, done=0 and remaining=6.
REQ-040 reset_n low mid-WR: expect dma_wr, dma_active and irq_done low immediately, and STATUS=0 after release.

Source files
------------

// File: rtl/pq_dma_pkg.sv
// Shared definitions for the peripheral DMA engine: register map,
// CTRL/STATUS bit positions and the engine state encoding.
package pq_dma_pkg;

  localparam logic [2:0] ADDR_SRC    = 3'd0;
  localparam logic [2:0] ADDR_DST    = 3'd1;
  localparam logic [2:0] ADDR_LEN    = 3'd2;
  localparam logic [2:0] ADDR_FILL   = 3'd3;
  localparam logic [2:0] ADDR_CTRL   = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  localparam int CTRL_START = 0;
  localparam int CTRL_MODE  = 1;
  localparam int CTRL_ABORT = 2;

  localparam int STAT_BUSY = 31;
  localparam int STAT_DONE = 30;

  localparam int ADDR_W = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } dma_state_e;

endpackage

// File: rtl/periph_dma.sv
// CPU-programmed single-channel DMA: copies SRC->DST or fills DST with a
// constant, one word per SDRAM request/ack handshake.
module periph_dma
  import pq_dma_pkg::*;
#(
  parameter int LEN_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reg_wr,
  input  logic [2:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic              dma_rd,
  output logic              dma_wr,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [31:0]       dma_wdata,
  output logic [3:0]        dma_wstrb,
  output logic              dma_active,
  input  logic              sdram_ack,
  input  logic [31:0]       sdram_rdata,
  output logic              irq_done
);

  dma_state_e        r_state;
  dma_state_e        w_state_nxt;

  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [31:0]       r_fill;
  logic              r_mode;
  logic              r_done;
  logic              r_irq;
  logic              r_abort_pend;

  logic [ADDR_W-1:0] r_wsrc;
  logic [ADDR_W-1:0] r_wdst;
  logic [LEN_W-1:0]  r_rem;
  logic [31:0]       r_data;

  logic              w_busy;
  logic              w_ctrl_wr;
  logic              w_start_req;
  logic              w_abort_req;
  logic              w_abort;
  logic              w_launch;
  logic              w_zero_start;
  logic              w_finish;
  logic              w_aborted;
  logic              w_rd_ack;
  logic              w_wr_ack;
  logic [23:0]       w_rem24;

  assign w_busy      = (r_state != IDLE);
  assign w_ctrl_wr   = reg_wr && (reg_addr == ADDR_CTRL);
  // Abort in the same write as start wins; the start is dropped.
  assign w_start_req = w_ctrl_wr && reg_wdata[CTRL_START] && !reg_wdata[CTRL_ABORT];
  assign w_abort_req = w_ctrl_wr && reg_wdata[CTRL_ABORT];
  assign w_abort     = r_abort_pend || (w_abort_req && w_busy);
  assign w_rd_ack    = (r_state == RD) && sdram_ack;
  assign w_wr_ack    = (r_state == WR) && sdram_ack;
  assign w_rem24     = 24'(r_rem);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_launch     = 1'b0;
    w_zero_start = 1'b0;
    w_finish     = 1'b0;
    w_aborted    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_req) begin
          if (r_len == '0) begin
            w_zero_start = 1'b1;
          end else begin
            w_launch    = 1'b1;
            w_state_nxt = reg_wdata[CTRL_MODE] ? WR : RD;
          end
        end
      end
      RD: begin
        if (sdram_ack) begin
          if (w_abort) begin
            w_state_nxt = IDLE;
            w_aborted   = 1'b1;
          end else begin
            w_state_nxt = WR;
          end
        end
      end
      WR: begin
        if (sdram_ack) begin
          if (w_abort) begin
            w_state_nxt = IDLE;
            w_aborted   = 1'b1;
          end else if (r_rem == LEN_W'(1)) begin
            w_state_nxt = IDLE;
            w_finish    = 1'b1;
          end else begin
            w_state_nxt = r_mode ? WR : RD;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src        <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_fill       <= '0;
      r_mode       <= 1'b0;
      r_done       <= 1'b0;
      r_irq        <= 1'b0;
      r_abort_pend <= 1'b0;
      r_wsrc       <= '0;
      r_wdst       <= '0;
      r_rem        <= '0;
      r_data       <= '0;
    end else begin
      r_irq <= w_zero_start | w_finish | w_aborted;

      // Programming is frozen while a job runs so a re-start repeats it.
      if (reg_wr && !w_busy) begin
        case (reg_addr)
          ADDR_SRC:  r_src  <= reg_wdata[ADDR_W-1:0];
          ADDR_DST:  r_dst  <= reg_wdata[ADDR_W-1:0];
          ADDR_LEN:  r_len  <= reg_wdata[LEN_W-1:0];
          ADDR_FILL: r_fill <= reg_wdata;
          ADDR_CTRL: r_mode <= reg_wdata[CTRL_MODE];
          default: ;
        endcase
      end

      if (w_launch) begin
        r_wsrc <= r_src;
        r_wdst <= r_dst;
        r_rem  <= r_len;
        r_done <= 1'b0;
      end

      if (w_zero_start) begin
        r_rem  <= '0;
        r_done <= 1'b1;
      end

      if (w_finish) begin
        r_done <= 1'b1;
      end

      // Address counters wrap naturally at 2^24.
      if (w_rd_ack) begin
        r_data <= sdram_rdata;
        r_wsrc <= r_wsrc + 24'd1;
      end

      if (w_wr_ack) begin
        r_wdst <= r_wdst + 24'd1;
        r_rem  <= r_rem - LEN_W'(1);
      end

      if (w_state_nxt == IDLE) begin
        r_abort_pend <= 1'b0;
      end else if (w_abort_req && w_busy) begin
        r_abort_pend <= 1'b1;
      end
    end
  end

  // Request outputs decode only flopped state, never the ack input.
  always_comb begin
    dma_rd     = (r_state == RD);
    dma_wr     = (r_state == WR);
    dma_active = w_busy;
    dma_wstrb  = 4'b1111;
    irq_done   = r_irq;
    dma_addr   = '0;
    dma_wdata  = '0;
    if (r_state == RD) begin
      dma_addr = r_wsrc;
    end else if (r_state == WR) begin
      dma_addr  = r_wdst;
      dma_wdata = r_mode ? r_fill : r_data;
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_SRC:  reg_rdata = {8'd0, r_src};
      ADDR_DST:  reg_rdata = {8'd0, r_dst};
      ADDR_LEN:  reg_rdata = 32'(r_len);
      ADDR_FILL: reg_rdata = r_fill;
      ADDR_CTRL: reg_rdata[CTRL_MODE] = r_mode;
      ADDR_STATUS: begin
        reg_rdata[STAT_BUSY] = w_busy;
        reg_rdata[STAT_DONE] = r_done;
        reg_rdata[23:0]      = w_rem24;
      end
      default: reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_periph_dma.sv
// Scoreboard bench for periph_dma: an SDRAM responder acks requests after a
// programmable delay and checks each one against the expected queue.
module tb_periph_dma;
  import pq_dma_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        reg_wr;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        dma_rd;
  logic        dma_wr;
  logic [23:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_wstrb;
  logic        dma_active;
  logic        sdram_ack;
  logic [31:0] sdram_rdata;
  logic        irq_done;

  typedef struct {
    bit          wr;
    logic [23:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t exp_q[$];

  int n_chk      = 0;
  int n_pass     = 0;
  int ack_dly    = 2;
  int wait_cnt   = 0;
  int irq_cnt    = 0;
  int rd_cyc     = 0;
  int req_cyc    = 0;
  int wr_ack_cnt = 0;

  periph_dma #(.LEN_W(24)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .reg_wr      (reg_wr),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .dma_rd      (dma_rd),
    .dma_wr      (dma_wr),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_wstrb   (dma_wstrb),
    .dma_active  (dma_active),
    .sdram_ack   (sdram_ack),
    .sdram_rdata (sdram_rdata),
    .irq_done    (irq_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_fn(input logic [23:0] a);
    return {a[7:0], a} ^ 32'h5A5A_0000;
  endfunction

  task automatic push_txn(input bit wr, input logic [23:0] addr, input logic [31:0] data);
    txn_t t;
    t.wr = wr; t.addr = addr; t.data = data;
    exp_q.push_back(t);
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge clk); #1;
    reg_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    reg_addr = a;
    #1;
    d = reg_rdata;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while (dma_active && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 64'(dma_active), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // SDRAM responder and scoreboard consumer, sampling on the falling edge.
  initial begin
    sdram_ack   = 1'b0;
    sdram_rdata = '0;
    forever begin
      @(negedge clk);
      if (irq_done) irq_cnt++;
      if (dma_rd) rd_cyc++;
      if (dma_rd || dma_wr) req_cyc++;
      if (dma_rd && dma_wr) check("rd_wr_exclusive", 64'd1, 64'd0);
      if (!reset_n) begin
        sdram_ack = 1'b0;
        wait_cnt  = 0;
      end else if (sdram_ack) begin
        sdram_ack = 1'b0;
        wait_cnt  = 0;
      end else if (dma_rd || dma_wr) begin
        wait_cnt++;
        if (wait_cnt >= ack_dly) begin
          sdram_ack = 1'b1;
          if (dma_rd) sdram_rdata = mem_fn(dma_addr);
          else wr_ack_cnt++;
          if (exp_q.size() == 0) begin
            check("sb_underflow", 64'({dma_wr, dma_addr}), 64'hFFFF_FFFF);
          end else begin
            txn_t e;
            e = exp_q.pop_front();
            check("sb_kind", 64'(dma_wr), 64'(e.wr));
            check("sb_addr", 64'(dma_addr), 64'(e.addr));
            if (e.wr) begin
              check("sb_wdata", 64'(dma_wdata), 64'(e.data));
              check("sb_wstrb", 64'(dma_wstrb), 64'hF);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] rd;
    reset_n   = 1'b0;
    reg_wr    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_dma_rd", 64'(dma_rd), 64'd0);
    check("rst_dma_wr", 64'(dma_wr), 64'd0);
    check("rst_active", 64'(dma_active), 64'd0);
    check("rst_irq", 64'(irq_done), 64'd0);
    check("rst_wstrb", 64'(dma_wstrb), 64'hF);
    reg_read(ADDR_STATUS, rd);
    check("rst_status", 64'(rd), 64'd0);
    reg_read(ADDR_SRC, rd);
    check("rst_src", 64'(rd), 64'd0);
    reset_n = 1'b1;

    // Copy of three words
    ack_dly = 2;
    reg_write(ADDR_SRC, 32'h0000_0100);
    reg_write(ADDR_DST, 32'h0000_0200);
    reg_write(ADDR_LEN, 32'd3);
    for (int i = 0; i < 3; i++) begin
      push_txn(1'b0, 24'h000100 + 24'(i), '0);
      push_txn(1'b1, 24'h000200 + 24'(i), mem_fn(24'h000100 + 24'(i)));
    end
    irq_cnt = 0;
    reg_write(ADDR_CTRL, 32'h1);
    check("copy_active", 64'(dma_active), 64'd1);
    wait_idle("copy_timeout", 200);
    check("copy_q_empty", 64'(exp_q.size()), 64'd0);
    check("copy_irq_cnt", 64'(irq_cnt), 64'd1);
    reg_read(ADDR_STATUS, rd);
    check("copy_status", 64'(rd), 64'h4000_0000);
    reg_read(ADDR_SRC, rd);
    check("copy_src_kept", 64'(rd), 64'h100);
    reg_read(ADDR_LEN, rd);
    check("copy_len_kept", 64'(rd), 64'd3);

    // Fill of four words
    reg_write(ADDR_FILL, 32'hDEAD_BEEF);
    reg_write(ADDR_DST, 32'h0000_0010);
    reg_write(ADDR_LEN, 32'd4);
    for (int i = 0; i < 4; i++) push_txn(1'b1, 24'h000010 + 24'(i), 32'hDEAD_BEEF);
    irq_cnt = 0;
    rd_cyc  = 0;
    reg_write(ADDR_CTRL, 32'h3);
    wait_idle("fill_timeout", 200);
    check("fill_q_empty", 64'(exp_q.size()), 64'd0);
    check("fill_no_rd", 64'(rd_cyc), 64'd0);
    check("fill_irq_cnt", 64'(irq_cnt), 64'd1);
    reg_read(ADDR_STATUS, rd);
    check("fill_status", 64'(rd), 64'h4000_0000);

    // Copy across the top of the address space
    reg_write(ADDR_SRC, 32'h00FF_FFFE);
    reg_write(ADDR_DST, 32'h0000_0300);
    reg_write(ADDR_LEN, 32'd3);
    for (int i = 0; i < 3; i++) begin
      logic [24:0] s;
      s = 25'h0FF_FFFE + 25'(i);
      push_txn(1'b0, s[23:0], '0);
      push_txn(1'b1, 24'h000300 + 24'(i), mem_fn(s[23:0]));
    end
    reg_write(ADDR_CTRL, 32'h1);
    wait_idle("wrap_timeout", 200);
    check("wrap_q_empty", 64'(exp_q.size()), 64'd0);

    // Zero-length start
    reg_write(ADDR_LEN, 32'd0);
    req_cyc = 0;
    irq_cnt = 0;
    reg_write(ADDR_CTRL, 32'h1);
    check("len0_irq_high", 64'(irq_done), 64'd1);
    check("len0_idle", 64'(dma_active), 64'd0);
    @(posedge clk); #1;
    check("len0_irq_low", 64'(irq_done), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("len0_no_req", 64'(req_cyc), 64'd0);
    check("len0_irq_cnt", 64'(irq_cnt), 64'd1);
    reg_read(ADDR_STATUS, rd);
    check("len0_status", 64'(rd), 64'h4000_0000);

    // Abort during the third read of an eight-word copy
    ack_dly = 5;
    reg_write(ADDR_SRC, 32'h0000_0400);
    reg_write(ADDR_DST, 32'h0000_0500);
    reg_write(ADDR_LEN, 32'd8);
    for (int i = 0; i < 2; i++) begin
      push_txn(1'b0, 24'h000400 + 24'(i), '0);
      push_txn(1'b1, 24'h000500 + 24'(i), mem_fn(24'h000400 + 24'(i)));
    end
    push_txn(1'b0, 24'h000402, '0);
    wr_ack_cnt = 0;
    irq_cnt    = 0;
    reg_write(ADDR_CTRL, 32'h1);
    reg_write(ADDR_SRC, 32'h0000_0ABC);
    begin
      int n = 0;
      while (!(wr_ack_cnt >= 2 && dma_rd) && n < 300) begin
        @(posedge clk); #1;
        n++;
      end
      check("abort_sync", 64'(wr_ack_cnt >= 2 && dma_rd), 64'd1);
    end
    reg_write(ADDR_CTRL, 32'h4);
    check("abort_req_held", 64'(dma_rd), 64'd1);
    check("abort_addr_held", 64'(dma_addr), 64'h402);
    wait_idle("abort_timeout", 100);
    check("abort_q_empty", 64'(exp_q.size()), 64'd0);
    check("abort_irq_cnt", 64'(irq_cnt), 64'd1);
    reg_read(ADDR_STATUS, rd);
    check("abort_status", 64'(rd), 64'h0000_0006);
    reg_read(ADDR_SRC, rd);
    check("busy_src_ignored", 64'(rd), 64'h400);

    // Abort and start together in idle: nothing happens
    reg_write(ADDR_CTRL, 32'h5);
    repeat (2) @(posedge clk);
    #1;
    check("abort_start_idle", 64'(dma_active), 64'd0);
    reg_read(ADDR_STATUS, rd);
    check("abort_start_status", 64'(rd), 64'h0000_0006);

    // Reset while a write is outstanding
    ack_dly = 3;
    reg_write(ADDR_DST, 32'h0000_0600);
    reg_write(ADDR_LEN, 32'd4);
    for (int i = 0; i < 4; i++) push_txn(1'b1, 24'h000600 + 24'(i), 32'hDEAD_BEEF);
    reg_write(ADDR_CTRL, 32'h3);
    begin
      int n = 0;
      while (!dma_wr && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      check("rstwr_sync", 64'(dma_wr), 64'd1);
    end
    reset_n = 1'b0;
    #1;
    check("rstwr_dma_wr", 64'(dma_wr), 64'd0);
    check("rstwr_active", 64'(dma_active), 64'd0);
    check("rstwr_irq", 64'(irq_done), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reg_read(ADDR_STATUS, rd);
    check("rstwr_status", 64'(rd), 64'd0);
    reg_read(ADDR_FILL, rd);
    check("rstwr_fill", 64'(rd), 64'd0);
    check("rstwr_idle", 64'(dma_active), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
